// File: rtl/life_pkg.sv
// Shared definitions for the life sequencer: FSM state encoding, default grid
// geometry, generation counter width and the period word width.
package life_pkg;

  localparam int ROWS_DEF  = 8;
  localparam int COLS_DEF  = 8;
  localparam int GEN_W_DEF = 16;
  localparam int PERIOD_W  = 30;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_STEP  = 3'd5
  } life_state_e;

endpackage

// File: rtl/life_sequencer_if.sv
// Row-load handshake between a pattern source (master) and the sequencer (slave).
interface life_sequencer_if #(
  parameter int COLS = 8
);

  logic            load_valid;
  logic [COLS-1:0] load_row;
  logic            load_ready;

  modport master (output load_valid, output load_row, input load_ready);
  modport slave  (input load_valid, input load_row, output load_ready);

endinterface

// File: rtl/gen_divider.sv
// Generation-rate divider: counts 0..max(period,1)-1 while enabled and emits a
// one-cycle tick on the terminal count; holds its value while disabled.
module gen_divider
  import life_pkg::*;
(
  input  logic                qzt_clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count_reg;
  logic [PERIOD_W-1:0] count_next;
  logic [PERIOD_W-1:0] term;

  // ">=" rather than "==" so a shrinking period wraps straight away
  assign term = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign tick = en && (count_reg >= term);

  always_comb begin
    count_next = count_reg;
    if (clr)
      count_next = '0;
    else if (tick)
      count_next = '0;
    else if (en)
      count_next = count_reg + PERIOD_W'(1);
  end

  always_ff @(posedge qzt_clk or posedge rst) begin
    if (rst)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

endmodule

// File: rtl/life_sequencer.sv
// Game-of-life sequencer: loads a start pattern, paces generations of an
// external cell array and stops it on extinction or still life.
module life_sequencer
  import life_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int GEN_W = GEN_W_DEF
) (
  input  logic                 qzt_clk,
  input  logic                 rst,
  input  logic [PERIOD_W-1:0]  period,
  input  logic                 cmd_run,
  input  logic                 cmd_pause,
  input  logic                 cmd_step,
  input  logic                 cmd_load,
  life_sequencer_if.slave      load_if,
  input  logic [ROWS*COLS-1:0] grid_state,
  output logic [ROWS*COLS-1:0] initial_state,
  output logic                 set_state,
  output logic                 gen_tick,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 running,
  output logic                 extinct,
  output logic                 still
);

  localparam logic [2:0] IDLE  = S_IDLE;
  localparam logic [2:0] LOAD  = S_LOAD;
  localparam logic [2:0] ARM   = S_ARM;
  localparam logic [2:0] RUN   = S_RUN;
  localparam logic [2:0] PAUSE = S_PAUSE;
  localparam logic [2:0] STEP  = S_STEP;
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [1:0]           rst_sync_reg;
  logic                 rst_int;
  logic [2:0]           state_reg;
  logic [2:0]           state_next;
  logic [RIDX_W-1:0]    row_idx_reg;
  logic [ROWS*COLS-1:0] sample_reg;
  logic [ROWS*COLS-1:0] snapshot_reg;
  logic                 eval_d1_reg;
  logic                 eval_d2_reg;
  logic [GEN_W-1:0]     gen_count_reg;
  logic                 extinct_reg;
  logic                 still_reg;
  logic                 load_we;
  logic                 row_last;
  logic                 eval_live;
  logic                 extinct_ev;
  logic                 still_ev;
  logic                 div_en;
  logic                 div_tick;

  // Reset asserts immediately but releases two edges later
  always_ff @(posedge qzt_clk or posedge rst) begin
    if (rst)
      rst_sync_reg <= 2'b11;
    else
      rst_sync_reg <= {rst_sync_reg[0], 1'b0};
  end
  assign rst_int = rst_sync_reg[1];

  assign load_we  = (state_reg == LOAD) && load_if.load_valid;
  assign row_last = (row_idx_reg == RIDX_W'(ROWS - 1));

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [COLS-1:0] row_reg;
    always_ff @(posedge qzt_clk or posedge rst_int) begin
      if (rst_int)
        row_reg <= '0;
      else if (load_we && (row_idx_reg == RIDX_W'(gi)))
        row_reg <= load_if.load_row;
    end
    assign initial_state[gi*COLS +: COLS] = row_reg;
  end

  // A verdict lands in states where the sequencer still owns the run
  assign eval_live  = eval_d2_reg &&
                      ((state_reg == RUN) || (state_reg == PAUSE) || (state_reg == STEP));
  assign extinct_ev = eval_live && (sample_reg == '0);
  assign still_ev   = eval_live && !extinct_ev && (sample_reg == snapshot_reg);

  assign div_en = (state_reg == RUN) && !extinct_ev && !still_ev && !cmd_pause;

  gen_divider u_div (
    .qzt_clk (qzt_clk),
    .rst     (rst_int),
    .en      (div_en),
    .clr     (state_reg == ARM),
    .period  (period),
    .tick    (div_tick)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_load)     state_next = LOAD;
        else if (cmd_run) state_next = ARM;
      end
      LOAD: begin
        if (load_we && row_last) state_next = IDLE;
      end
      ARM: state_next = RUN;
      RUN: begin
        if (extinct_ev)                state_next = IDLE;
        else if (still_ev || cmd_pause) state_next = PAUSE;
      end
      PAUSE: begin
        if (extinct_ev)     state_next = IDLE;
        else if (still_ev)  state_next = PAUSE;
        else if (cmd_load)  state_next = LOAD;
        else if (cmd_pause) state_next = PAUSE;
        else if (cmd_step)  state_next = STEP;
        else if (cmd_run)   state_next = RUN;
      end
      STEP: begin
        if (extinct_ev) state_next = IDLE;
        else            state_next = PAUSE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge qzt_clk or posedge rst_int) begin
    if (rst_int) begin
      state_reg     <= IDLE;
      row_idx_reg   <= '0;
      sample_reg    <= '0;
      snapshot_reg  <= '0;
      eval_d1_reg   <= 1'b0;
      eval_d2_reg   <= 1'b0;
      gen_count_reg <= '0;
      extinct_reg   <= 1'b0;
      still_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg != LOAD)
        row_idx_reg <= '0;
      else if (load_we)
        row_idx_reg <= row_idx_reg + RIDX_W'(1);
      // Capture one cycle after the cells update, judge it the cycle after
      eval_d1_reg <= gen_tick && (state_reg != ARM);
      eval_d2_reg <= eval_d1_reg;
      if (eval_d1_reg)
        sample_reg <= grid_state;
      if (state_reg == ARM) begin
        gen_count_reg <= '0;
        extinct_reg   <= 1'b0;
        still_reg     <= 1'b0;
        snapshot_reg  <= initial_state;
      end else begin
        if (gen_tick)
          gen_count_reg <= gen_count_reg + GEN_W'(1);
        if (extinct_ev)
          extinct_reg <= 1'b1;
        if (still_ev)
          still_reg <= 1'b1;
        if (eval_live)
          snapshot_reg <= sample_reg;
      end
    end
  end

  assign gen_tick           = (state_reg == ARM) || (state_reg == STEP) || div_tick;
  assign set_state          = (state_reg == ARM);
  assign load_if.load_ready = (state_reg == LOAD);
  assign running            = (state_reg == RUN);
  assign gen_count          = gen_count_reg;
  assign extinct            = extinct_reg;
  assign still              = still_reg;

endmodule

// File: tb/tb_life_sequencer.sv
// Bench for life_sequencer: a behavioural cell array feeds grid_state, and a
// scoreboard matches every gen_tick against the expected cycle and set_state.
module tb_life_sequencer;
  import life_pkg::*;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;
  localparam int C_LOAD = 0, C_PAUSE = 1, C_STEP = 2, C_RUN = 3;

  typedef struct packed {
    logic [31:0] at;
    logic        set;
  } tick_t;

  logic                qzt_clk = 1'b0;
  logic                rst;
  logic [PERIOD_W-1:0] period, period4;
  logic                cmd_run, cmd_pause, cmd_step, cmd_load;
  logic                run4, pause4;
  logic [N-1:0]        grid_state, initial_state, grid4, init4;
  logic [N-1:0]        cells = '0;
  logic                set_state, gen_tick, running, extinct, still;
  logic                set_state4, gen_tick4, running4, extinct4, still4;
  logic [15:0]         gen_count;
  logic [3:0]          gen_count4;
  logic [31:0]         cyc = '0;
  int                  errors = 0;
  int                  checks = 0;
  int                  tick4_cnt = 0;
  tick_t               exp_q[$];

  life_sequencer_if #(.COLS(COLS)) load_if ();
  life_sequencer_if #(.COLS(COLS)) load_if4 ();

  always #5 qzt_clk = ~qzt_clk;
  always @(posedge qzt_clk) cyc <= cyc + 1;

  life_sequencer #(.ROWS(ROWS), .COLS(COLS), .GEN_W(16)) u_dut (
    .qzt_clk(qzt_clk), .rst(rst), .period(period),
    .cmd_run(cmd_run), .cmd_pause(cmd_pause), .cmd_step(cmd_step), .cmd_load(cmd_load),
    .load_if(load_if), .grid_state(grid_state), .initial_state(initial_state),
    .set_state(set_state), .gen_tick(gen_tick), .gen_count(gen_count),
    .running(running), .extinct(extinct), .still(still)
  );

  life_sequencer #(.ROWS(ROWS), .COLS(COLS), .GEN_W(4)) u_dut4 (
    .qzt_clk(qzt_clk), .rst(rst), .period(period4),
    .cmd_run(run4), .cmd_pause(pause4), .cmd_step(1'b0), .cmd_load(1'b0),
    .load_if(load_if4), .grid_state(grid4), .initial_state(init4),
    .set_state(set_state4), .gen_tick(gen_tick4), .gen_count(gen_count4),
    .running(running4), .extinct(extinct4), .still(still4)
  );

  // Dead-boundary Conway rules
  function automatic logic [N-1:0] life_next(input logic [N-1:0] g);
    logic [N-1:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS &&
                c + dc >= 0 && c + dc < COLS)
              cnt += int'(g[(r + dr) * COLS + c + dc]);
        n[r * COLS + c] = (cnt == 3) || (g[r * COLS + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  always @(posedge qzt_clk) begin
    if (set_state)     cells <= initial_state;
    else if (gen_tick) cells <= life_next(cells);
  end
  assign grid_state = cells;
  // Always non-zero and different every cycle: never extinct, never still
  assign grid4 = {{(N - 8){1'b0}}, cyc[6:0], 1'b1};

  always @(negedge qzt_clk) begin
    tick_t e;
    if (gen_tick) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick cyc=%0d actual=tick required=none", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.at != cyc || e.set != set_state) begin
          errors++;
          $display("FAIL tick_seq actual cyc=%0d set=%0b required cyc=%0d set=%0b",
                   cyc, set_state, e.at, e.set);
        end else
          $display("tick cyc=%0d set_state=%0b gen_count=%0d ok", cyc, set_state, gen_count);
      end
    end
    if (gen_tick4 && !set_state4) tick4_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else
      $display("check %s = %0h ok", name, act);
  endtask

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge qzt_clk);
      #1;
    end
  endtask

  task automatic expect_tick(input logic [31:0] at, input logic set);
    tick_t t;
    t.at  = at;
    t.set = set;
    exp_q.push_back(t);
  endtask

  task automatic strobe(input int which);
    cmd_load  = (which == C_LOAD);
    cmd_pause = (which == C_PAUSE);
    cmd_step  = (which == C_STEP);
    cmd_run   = (which == C_RUN);
    step_clk(1);
    {cmd_load, cmd_pause, cmd_step, cmd_run} = '0;
  endtask

  task automatic do_load(input logic [N-1:0] pat, input int nrows);
    int wait_cnt;
    strobe(C_LOAD);
    for (int r = 0; r < nrows; r++) begin
      load_if.load_row   = pat[r * COLS +: COLS];
      load_if.load_valid = 1'b1;
      wait_cnt = 0;
      while (!load_if.load_ready && wait_cnt < 10) begin
        step_clk(1);
        wait_cnt++;
      end
      if (!load_if.load_ready) begin
        checks++;
        errors++;
        $display("FAIL load_ready_timeout row=%0d actual=0 required=1", r);
      end
      step_clk(1);
    end
    load_if.load_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] c, q;
    rst = 1'b1;
    period = 30'd4;
    period4 = 30'd0;
    {cmd_load, cmd_pause, cmd_step, cmd_run} = '0;
    run4 = 1'b0;
    pause4 = 1'b0;
    load_if.load_valid = 1'b0;
    load_if.load_row = '0;
    load_if4.load_valid = 1'b0;
    load_if4.load_row = '0;
    step_clk(4);
    check("rst_outputs", {gen_tick, set_state, load_if.load_ready, running, extinct, still}, 0);
    check("rst_gen_count", gen_count, 0);
    check("rst_initial_state", initial_state, 0);

    // A command on the first edge after release must still be ignored
    rst = 1'b0;
    cmd_load = 1'b1;
    step_clk(1);
    cmd_load = 1'b0;
    check("sync_release_ignores_cmd", load_if.load_ready, 0);
    step_clk(3);

    // Block still life, period 4
    do_load(64'h0000_0000_0000_1818, 8);
    check("block_initial_state", initial_state, 64'h0000_0000_0000_1818);
    check("load_ready_after_load", load_if.load_ready, 0);
    c = cyc;
    strobe(C_RUN);
    expect_tick(c + 1, 1'b1);
    expect_tick(c + 5, 1'b0);
    step_clk(3);
    check("block_running", running, 1);
    step_clk(5);
    check("block_still", still, 1);
    check("block_extinct", extinct, 0);
    check("block_paused", running, 0);
    check("block_gen_count", gen_count, 1);

    // Single step from PAUSE
    c = cyc;
    strobe(C_STEP);
    expect_tick(c + 1, 1'b0);
    step_clk(5);
    check("step_gen_count", gen_count, 2);
    check("step_running", running, 0);

    // Blinker, period 1, ten generations then pause on a terminal count
    do_load(64'h0000_0004_0404_0000, 8);
    check("blinker_initial_state", initial_state, 64'h0000_0004_0404_0000);
    period = 30'd1;
    c = cyc;
    strobe(C_RUN);
    expect_tick(c + 1, 1'b1);
    for (int i = 2; i <= 11; i++) expect_tick(c + i, 1'b0);
    step_clk(11);
    strobe(C_PAUSE);
    step_clk(3);
    check("blinker_gen_count", gen_count, 10);
    check("blinker_still", still, 0);
    check("blinker_extinct", extinct, 0);
    check("blinker_paused", running, 0);

    // Divider holds across a pause: resume at count 2 of period 5
    period = 30'd5;
    c = cyc;
    strobe(C_RUN);
    expect_tick(c + 5, 1'b0);
    step_clk(7);
    strobe(C_PAUSE);
    step_clk(20);
    q = cyc;
    strobe(C_RUN);
    expect_tick(q + 3, 1'b0);
    step_clk(3);
    strobe(C_PAUSE);
    step_clk(1);
    c = cyc;
    strobe(C_STEP);
    expect_tick(c + 1, 1'b0);
    step_clk(5);
    check("resume_gen_count", gen_count, 13);
    check("resume_paused", running, 0);

    // Single live cell dies on the first evaluation
    do_load(64'h0000_0000_0800_0000, 8);
    period = 30'd2;
    c = cyc;
    strobe(C_RUN);
    expect_tick(c + 1, 1'b1);
    expect_tick(c + 3, 1'b0);
    step_clk(7);
    check("single_extinct", extinct, 1);
    check("single_still", still, 0);
    check("single_gen_count", gen_count, 1);
    check("single_running", running, 0);
    strobe(C_STEP);
    step_clk(3);

    // Reset in the middle of a load discards the partial pattern
    do_load(64'hAAAA_AAAA_AAAA_AAAA, 3);
    rst = 1'b1;
    #1;
    check("midload_rst_ready", load_if.load_ready, 0);
    check("midload_rst_initial_state", initial_state, 0);
    check("midload_rst_flags", {extinct, still, running}, 0);
    check("midload_rst_gen_count", gen_count, 0);
    step_clk(2);
    rst = 1'b0;
    step_clk(3);
    do_load(64'h8877_6655_4433_2211, 8);
    check("reload_initial_state", initial_state, 64'h8877_6655_4433_2211);

    // GEN_W=4 instance with period 0: 17 ticks wrap the count to 1
    c = cyc;
    run4 = 1'b1;
    step_clk(1);
    run4 = 1'b0;
    step_clk(18);
    pause4 = 1'b1;
    step_clk(1);
    pause4 = 1'b0;
    step_clk(3);
    check("gen4_tick_count", tick4_cnt, 17);
    check("gen4_gen_count", gen_count4, 1);
    check("gen4_running", running4, 0);

    step_clk(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/life_sequencer.md
LIFE_SEQUENCER -- requirements
Module: life_sequencer

Interface
REQ-001 Parameter ROWS, default 8, grid height in cells.
REQ-002 Parameter COLS, default 8, grid width in cells.
REQ-003 Parameter GEN_W, default 16, generation counter width.
REQ-004 qzt_clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 period  in  30  qzt_clk cycles per generation; 0 is treated as 1.
REQ-007 cmd_run / cmd_pause / cmd_step / cmd_load  in  1 each  single-cycle command strobes.
REQ-008 load_valid  in  1; load_row  in  COLS  row-load handshake, rows 0..ROWS-1 in order.
REQ-009 load_ready  out  1  high only in LOAD.
REQ-010 grid_state  in  ROWS*COLS  current cell states from the cell array, bit r*COLS+c.
REQ-011 initial_state  out  ROWS*COLS  pattern buffer driven to the cells.
REQ-012 set_state  out  1  high for exactly one gen_tick, forcing cells to initial_state.
REQ-013 gen_tick  out  1  one-cycle generation enable to the cell array.
REQ-014 gen_count  out  GEN_W  generations advanced since last ARM.
REQ-015 running  out  1; extinct  out  1; still  out  1  status flags.

Function
REQ-016 FSM states: IDLE, LOAD, ARM, RUN, PAUSE, STEP.
REQ-017 IDLE: cmd_load -> LOAD; cmd_run -> ARM; other commands ignored.
REQ-018 LOAD: row_idx from 0; each cycle with load_valid && load_ready writes load_row into row row_idx and increments row_idx; after row ROWS-1 is written -> IDLE next cycle.
REQ-019 LOAD: any cmd_* ignored; load_valid outside LOAD ignored.
REQ-020 ARM: assert set_state together with one gen_tick; clear gen_count, extinct and still; -> RUN next cycle.
REQ-021 Divider: counter counts 0..max(period,1)-1 in RUN only; at terminal count it emits gen_tick for one cycle and wraps to 0.
REQ-022 Divider: counter cleared on entry to RUN; a period change takes effect at the next wrap, or immediately if counter >= new period-1.
REQ-023 RUN: each gen_tick increments gen_count, which wraps modulo 2^GEN_W.
REQ-024 RUN: cmd_pause -> PAUSE, and the divider holds its value.
REQ-025 PAUSE: cmd_run -> RUN with the divider resumed; cmd_step -> STEP; cmd_load -> LOAD.
REQ-026 STEP: one gen_tick plus gen_count increment in its single cycle, then -> PAUSE.
REQ-027 Evaluation: grid_state is sampled two cycles after every non-ARM gen_tick, giving the cells one cycle to update plus one cycle of margin.
REQ-028 Extinction: if sampled grid_state == 0, set extinct and go -> IDLE.
REQ-029 Still life: if sampled grid_state equals the snapshot from the previous generation, set still and go -> PAUSE; the snapshot is then updated.
REQ-030 Precedence for simultaneous events: extinction > still > command strobe > divider tick; if the divider terminal count coincides with cmd_pause, no gen_tick is issued.
REQ-031 Multiple strobes in one cycle: priority cmd_load > cmd_pause > cmd_step > cmd_run.
REQ-032 running = 1 exactly in RUN.

Reset
REQ-033 rst forces IDLE, divider = 0, row_idx = 0, gen_count = 0, and outputs gen_tick, set_state, load_ready, running, extinct, still = 0.
REQ-034 rst clears initial_state and the snapshot to all zeros; rst during LOAD discards the partial load.
REQ-035 Deassertion of rst is synchronised internally, and the first transition occurs no earlier than the second qzt_clk edge after release.

Structure
REQ-036 Shared package life_pkg holds the FSM state enum, the default ROWS/COLS/GEN_W constants and the period width constant (30).
REQ-037 The divider is a separate sub-module gen_divider (inputs qzt_clk, rst, en, clr, period; output tick).
REQ-038 The cell array is not instantiated here; life_sequencer connects to it only through gen_tick, set_state, initial_state and grid_state.

Verification
REQ-039 Load ROWS=8 rows 8'h18, 8'h18, 0..., then cmd_run, period=4 -> set_state is 1 for one cycle, then gen_tick every 4 cycles; a still-life block pattern -> still=1 and PAUSE after gen_count=1.
REQ-040 Blinker pattern, period=1, 10 generations -> gen_tick every cycle, gen_count=10, still=0, extinct=0.
REQ-041 Single live cell, cmd_run -> after the first evaluation extinct=1, state IDLE, gen_count=1.
REQ-042 In RUN at divider=2 (period=5): cmd_pause, wait 20 cycles, cmd_run -> next gen_tick exactly 3 cycles later (counter values 2, 3, 4 then wrap); cmd_step in PAUSE -> exactly one gen_tick.
REQ-043 Assert rst mid-LOAD after 3 rows -> load_ready=0, initial_state=0, IDLE; a fresh cmd_load restarts at row 0.
REQ-044 period=0 -> behaves as period=1; GEN_W=4 run of 17 ticks -> gen_count=1.
